// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: icache request/response, hazard/redirect inputs and IF/ID latch outputs.
// Optional FETCH_PERF_EN adds the fetch_count/stall_count performance counters.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        ifW;
    logic        ifRST;
    logic [31:0] ifinstr;
    logic [31:0] ifiaddr;
    logic [31:0] ifJALjump_addr;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  ihit, imemload, stall, redirect, redirect_addr,
        output imemREN, imemaddr, ifW, ifRST, ifinstr, ifiaddr, ifJALjump_addr
`ifdef FETCH_PERF_EN
        , output fetch_count, stall_count
`endif
    );

    modport slave (
        output ihit, imemload, stall, redirect, redirect_addr,
        input  imemREN, imemaddr, ifW, ifRST, ifinstr, ifiaddr, ifJALjump_addr
`ifdef FETCH_PERF_EN
        , input fetch_count, stall_count
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, icache request, redirect/squash and halt handling.
// Define FETCH_PERF_EN to add the fetch/stall performance counters.
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic           CLK,
    input logic           nRST,
    fetch_stage_if.master fs
);
    typedef enum logic [1:0] {StFetch, StSquash, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        if_w, if_rst;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        if_w    = 1'b0;
        if_rst  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (fs.redirect) begin
                    if_rst = 1'b1;
                    if (fs.ihit) begin
                        pc_d = fs.redirect_addr;
                    end else begin
                        // Miss in flight: keep the request stable, remember where to go.
                        tgt_d   = fs.redirect_addr;
                        state_d = StSquash;
                    end
                end else if (fs.ihit && !fs.stall) begin
                    if_w = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (fs.imemload == HALT_WORD) state_d = StHalted;
                end
            end
            StSquash: begin
                if (fs.redirect) begin
                    tgt_d  = fs.redirect_addr;
                    if_rst = 1'b1;
                end
                if (fs.ihit) begin
                    pc_d    = fs.redirect ? fs.redirect_addr : tgt_q;
                    state_d = StFetch;
                end
            end
            StHalted: begin
                if (fs.redirect) begin
                    if_rst  = 1'b1;
                    pc_d    = fs.redirect_addr;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StFetch;
            pc_q    <= PC_INIT;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Latch controls are forced low while reset is held, regardless of inputs.
    assign fs.ifW            = if_w & nRST;
    assign fs.ifRST          = if_rst & nRST;
    assign fs.imemREN        = (state_q != StHalted);
    assign fs.imemaddr       = pc_q;
    assign fs.ifinstr        = fs.imemload;
    assign fs.ifiaddr        = pc_q;
    assign fs.ifJALjump_addr = pc_q + 32'd4;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (if_w) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if ((state_q != StHalted) && !if_w) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fs.fetch_count = fetch_cnt_q;
    assign fs.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table through a scoreboard queue plus
// a hand-written asynchronous-reset-in-squash sequence.
module tb_fetch_stage;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic        ihit;
        logic [31:0] load;
        logic [31:0] raddr;
        logic        e_w;
        logic        e_rst;
        logic        e_ren;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        logic        e_w;
        logic        e_rst;
        logic        e_ren;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
    } exp_t;

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;
    int   m_fetch;
    int   m_stall;
    vec_t vecs[$];
    exp_t sb[$];

    fetch_stage_if fs ();

    fetch_stage #(
        .PC_INIT  (32'h0000_0000),
        .HALT_WORD(HALT)
    ) dut (
        .CLK (clk),
        .nRST(n_rst),
        .fs  (fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic hit,
                                input logic [31:0] load, input logic [31:0] raddr,
                                input logic ew, input logic erst, input logic eren,
                                input logic [31:0] eaddr);
        vec_t v;
        v.stall = st;  v.redirect = rd; v.ihit = hit; v.load = load; v.raddr = raddr;
        v.e_w = ew;    v.e_rst = erst;  v.e_ren = eren; v.e_addr = eaddr;
        return v;
    endfunction

    task automatic compare_out(input int row);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty row=%0d got=0 exp=1", row);
        end else begin
            e = sb.pop_front();
            chk("ifW", row, {31'h0, fs.ifW}, {31'h0, e.e_w});
            chk("ifRST", row, {31'h0, fs.ifRST}, {31'h0, e.e_rst});
            chk("imemREN", row, {31'h0, fs.imemREN}, {31'h0, e.e_ren});
            chk("imemaddr", row, fs.imemaddr, e.e_addr);
            chk("ifiaddr", row, fs.ifiaddr, e.e_addr);
            chk("ifJALjump_addr", row, fs.ifJALjump_addr, e.e_addr + 32'd4);
            chk("ifinstr", row, fs.ifinstr, e.e_instr);
        end
    endtask

    // Called at posedge+1; drives a row, checks at negedge, returns at next posedge+1.
    task automatic apply(input vec_t v, input int row);
        exp_t e;
        fs.stall = v.stall; fs.redirect = v.redirect; fs.ihit = v.ihit;
        fs.imemload = v.load; fs.redirect_addr = v.raddr;
        e.e_w = v.e_w; e.e_rst = v.e_rst; e.e_ren = v.e_ren;
        e.e_addr = v.e_addr; e.e_instr = v.load;
        sb.push_back(e);
        if (v.e_w) m_fetch++;
        else if (v.e_ren) m_stall++;
        @(negedge clk);
        compare_out(row);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; m_fetch = 0; m_stall = 0;

        //          st rd hit load          raddr         w  rst ren addr
        vecs.push_back(mk(0, 0, 1, 32'h0000_0011, 32'h0, 1, 0, 1, 32'h00)); // 0
        vecs.push_back(mk(0, 0, 1, 32'h0000_0012, 32'h0, 1, 0, 1, 32'h04));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0013, 32'h0, 0, 0, 1, 32'h08)); // stall x3
        vecs.push_back(mk(1, 0, 1, 32'h0000_0013, 32'h0, 0, 0, 1, 32'h08));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0013, 32'h0, 0, 0, 1, 32'h08));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0013, 32'h0, 1, 0, 1, 32'h08));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0014, 32'h0, 1, 0, 1, 32'h0C));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0015, 32'h40, 0, 1, 1, 32'h10)); // redirect on hit
        vecs.push_back(mk(0, 1, 1, 32'h0000_0016, 32'h20, 0, 1, 1, 32'h40));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0017, 32'h80, 0, 1, 1, 32'h20)); // miss -> squash
        vecs.push_back(mk(0, 0, 0, 32'h0000_0017, 32'h0, 0, 0, 1, 32'h20));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0017, 32'h90, 0, 1, 1, 32'h20)); // last wins
        vecs.push_back(mk(1, 0, 0, 32'h0000_0017, 32'h0, 0, 0, 1, 32'h20));
        vecs.push_back(mk(0, 0, 1, HALT, 32'h0, 0, 0, 1, 32'h20)); // squashed data
        vecs.push_back(mk(0, 0, 1, HALT, 32'h0, 1, 0, 1, 32'h90)); // halt written once
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, 1, HALT, 32'h0, 0, 0, 0, 32'h94));
        vecs.push_back(mk(0, 1, 0, HALT, 32'h100, 0, 1, 0, 32'h94)); // leave halt
        vecs.push_back(mk(0, 0, 1, 32'h0000_0021, 32'h0, 1, 0, 1, 32'h100));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0022, 32'hFFFF_FFFC, 0, 1, 1, 32'h104));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0023, 32'h0, 1, 0, 1, 32'hFFFF_FFFC)); // wrap
        vecs.push_back(mk(0, 0, 0, 32'h0000_0024, 32'h0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0025, 32'h50, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0026, 32'h200, 0, 1, 1, 32'h50)); // into squash

        // Reset state, with inputs that would otherwise write/flush.
        n_rst = 1'b0;
        fs.stall = 1'b0; fs.redirect = 1'b1; fs.ihit = 1'b1;
        fs.imemload = 32'h1234_5678; fs.redirect_addr = 32'h44;
        #2;
        chk("rst_ifW", -1, {31'h0, fs.ifW}, 32'h0);
        chk("rst_ifRST", -1, {31'h0, fs.ifRST}, 32'h0);
        chk("rst_imemREN", -1, {31'h0, fs.imemREN}, 32'h1);
        chk("rst_imemaddr", -1, fs.imemaddr, 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef FETCH_PERF_EN
        chk("fetch_count", -2, fs.fetch_count, m_fetch);
        chk("stall_count", -2, fs.stall_count, m_stall);
`endif

        // Asynchronous reset in the middle of a squash.
        fs.redirect = 1'b0; fs.ihit = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_imemaddr", -3, fs.imemaddr, 32'h0);
        chk("arst_imemREN", -3, {31'h0, fs.imemREN}, 32'h1);
        chk("arst_ifW", -3, {31'h0, fs.ifW}, 32'h0);
        chk("arst_ifRST", -3, {31'h0, fs.ifRST}, 32'h0);
`ifdef FETCH_PERF_EN
        chk("arst_fetch_count", -3, fs.fetch_count, 32'h0);
        chk("arst_stall_count", -3, fs.stall_count, 32'h0);
`endif
        fs.redirect = 1'b1; fs.ihit = 1'b1; fs.redirect_addr = 32'h300;
        #1;
        chk("arst_hold_ifW", -4, {31'h0, fs.ifW}, 32'h0);
        chk("arst_hold_ifRST", -4, {31'h0, fs.ifRST}, 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_addr", -4, fs.imemaddr, 32'h0);
        n_rst = 1'b1;
        apply(mk(0, 0, 1, 32'h0000_0031, 32'h0, 1, 0, 1, 32'h0), 100);
        apply(mk(0, 0, 1, 32'h0000_0032, 32'h0, 1, 0, 1, 32'h4), 101);
        apply(mk(0, 0, 0, 32'h0000_0033, 32'h0, 0, 0, 1, 32'h8), 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
